mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide engine with its own HI/LO result registers.
- Replaces the separate mult and div units, and the HI/LO/MultDiv muxing, in the multicycle datapath.
- Supports signed and unsigned multiply and divide, direct HI/LO writes (MTHI/MTLO) and divide-by-zero flagging.
- Uses a start/busy/done handshake so the control unit can stall on it.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request operation; sampled only in IDLE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  in  WIDTH  multiplicand / dividend; latched on accepted start
b  in  WIDTH  multiplier / divisor; latched on accepted start
hi_we  in  1  write wdata into HI; honoured only in IDLE
lo_we  in  1  write wdata into LO; honoured only in IDLE
wdata  in  WIDTH  data for hi_we/lo_we
busy  out  1  high in CALC and FIX
done  out  1  one-cycle pulse in DONE
div_zero  out  1  last completed op was DIV/DIVU with b==0
hi  out  WIDTH  MULT*: upper product half; DIV*: remainder
lo  out  WIDTH  MULT*: lower product half; DIV*: quotient

Behaviour:
- Reset (async, any state): state=IDLE; hi, lo, div_zero, busy, done = 0; internal counters and operand registers = 0. Any operation in flight is abandoned with no result written.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1:
  - Latch op. Latch |a|, |b| for signed ops or raw a, b for unsigned ops. Record the result signs.
  - Clear div_zero; load counter with WIDTH.
  - If op is DIV/DIVU and b==0: next state DONE, div_zero<=1, hi/lo unchanged.
  - Otherwise: next state CALC.
- IDLE with start=0: hi_we/lo_we write wdata into HI/LO on the clock edge. Both may be asserted in the same cycle. When start=1, hi_we/lo_we are ignored that cycle.
- CALC: one bit per cycle for exactly WIDTH cycles, then FIX.
  - Multiply: shift-add on a 2*WIDTH unsigned accumulator.
  - Divide: restoring shift-subtract producing an unsigned quotient and remainder.
- FIX (1 cycle): apply the sign correction, then write hi/lo.
  - Signed product is negated (two's complement over 2*WIDTH) when the operand signs differ.
  - Signed quotient is negated when the operand signs differ; it truncates toward zero.
  - Signed remainder takes the sign of the dividend.
  - The hi/lo write occurs on the edge leaving FIX.
- DONE (1 cycle): done=1, then return to IDLE. start during DONE is ignored.
- Latency: start accepted in cycle 0; busy=1 in cycles 1..WIDTH+1; done=1 in cycle WIDTH+2; hi/lo are valid from cycle WIDTH+2.
- Divide by zero: done=1 in cycle 1; busy never asserts.
- start, hi_we and lo_we during busy are ignored. Operand inputs may change freely after acceptance.
- Signed overflow: DIV of the most negative value by -1 gives lo=most negative value, hi=0. This falls out of the magnitude algorithm and gets no special handling.
- hi, lo and div_zero hold their values until the next completed op, an IDLE write, or reset.
- Arithmetic is modulo 2^WIDTH per half; no other flags are produced.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 34 cycles after the start cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1..33.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT on the same operands -> hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. div_zero=0 in both cases.
4. DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done in cycle 1; div_zero=1; hi=0x11, lo=0x22 unchanged; busy never high. The next accepted start clears div_zero.
5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Repeat at WIDTH=8: DIV a=0x80, b=0xFF -> lo=0x80, hi=0, done at cycle 10.
6. Interference and reset:
   - Start MULTU 6*7; at cycle 5 pulse start with new operands and hi_we=1 -> both ignored; result hi=0, lo=42.
   - In IDLE, hi_we=lo_we=1, wdata=0xABCD -> hi=lo=0xABCD.
   - Assert reset at cycle 10 of a new op -> state IDLE; hi, lo, busy, done, div_zero = 0 immediately (asynchronous); no done pulse follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine: one bit per cycle, with HI/LO result registers.
// Latency WIDTH+2 cycles (1 for divide-by-zero). While busy, start and hi_we/lo_we are ignored.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, state_nxt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mb;
   logic [2*WIDTH-1:0] acc;

   logic               signed_op;
   logic               b_zero_div;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shl;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      signed_op  = ~op[0];
      b_zero_div = op[1] && (b == '0);
      a_mag      = (signed_op && a[WIDTH-1]) ? -a : a;
      b_mag      = (signed_op && b[WIDTH-1]) ? -b : b;

      // Multiply: conditional add into the upper half, then shift the whole accumulator right.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      // Divide: acc holds {remainder, dividend/quotient}; restore by keeping the unsubtracted value.
      div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_shl - {1'b0, mb};
      div_next = div_diff[WIDTH] ? {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = b_zero_div ? DONE : CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         cnt      <= '0;
         mb       <= '0;
         acc      <= '0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_q    <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r    <= signed_op && a[WIDTH-1];
                  mb       <= b_mag;
                  acc      <= {{WIDTH{1'b0}}, a_mag};
                  cnt      <= CNT_W'(WIDTH);
                  div_zero <= b_zero_div;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem;
                  lo <= quo;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   logic         start8;
   logic [1:0]   op8;
   logic [7:0]   a8, b8, wdata8, hi8, lo8;
   logic         hi_we8, lo_we8, busy8, done8, dz8;

   int vectors = 0;
   int errors  = 0;
   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_dz;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
      .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy;
      logic [63:0] p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o[1] && y == '0) begin
         exp_dz = 1'b1;
         return;
      end
      exp_dz = 1'b0;
      case (o)
         2'b00: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         2'b01: begin p = {32'b0, x} * {32'b0, y}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         2'b10: begin q = sx / sy; r = sx % sy; exp_lo = q[31:0]; exp_hi = r[31:0]; end
         default: begin exp_lo = x / y; exp_hi = x % y; end
      endcase
   endtask

   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit interfere);
      int lat;
      logic [W-1:0] ph, pl;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      ph = exp_hi; pl = exp_lo;
      model(o, x, y);
      lat = exp_dz ? 1 : W + 2;
      for (int n = 1; n <= lat; n++) begin
         @(negedge clk);
         check("busy", busy, (!exp_dz && n <= W + 1));
         check("done", done, (n == lat));
         if (n == 1) begin
            check("div_zero_at_accept", div_zero, exp_dz);
            check("hi_hold", hi, ph);
            check("lo_hold", lo, pl);
         end
         start = interfere && (n == 5);
         hi_we = start;
         lo_we = start;
         op    = 2'($urandom);
         a     = $urandom;
         b     = $urandom;
         wdata = $urandom;
      end
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      check("div_zero", div_zero, exp_dz);
   endtask

   task automatic write_hl(input logic h, input logic l, input logic [W-1:0] d);
      @(negedge clk);
      start = 1'b0; hi_we = h; lo_we = l; wdata = d;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      if (h) exp_hi = d;
      if (l) exp_lo = d;
      check("write_hi", hi, exp_hi);
      check("write_lo", lo, exp_lo);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int cyc;
      bit saw_done;
      logic [1:0] ro;
      logic [W-1:0] rx, ry;

      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
      a = '0; b = '0; wdata = '0;
      start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0; hi_we8 = 1'b0; lo_we8 = 1'b0;
      exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", {busy, done, div_zero, hi, lo}, '0);
      reset = 1'b0;

      do_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
      check("t1_hi", hi, 32'hFFFFFFFF);
      check("t1_lo", lo, 32'hFFFFFFEB);

      do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("t2u_hi", hi, 32'hFFFFFFFE);
      check("t2u_lo", lo, 32'h00000001);
      do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("t2s_hilo", {hi, lo}, 64'h1);

      do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("t3s_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
      do_op(2'b11, 32'd7, 32'd2, 1'b0);
      check("t3u_hilo", {hi, lo}, {32'd1, 32'd3});

      write_hl(1'b1, 1'b0, 32'h11);
      write_hl(1'b0, 1'b1, 32'h22);
      do_op(2'b10, 32'd5, 32'd0, 1'b0);
      check("t4_hilo", {hi, lo}, {32'h11, 32'h22});
      check("t4_dz", div_zero, 1'b1);
      do_op(2'b11, 32'd100, 32'd9, 1'b0);

      do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("t5_hilo", {hi, lo}, {32'h0, 32'h80000000});

      @(negedge clk);
      start8 = 1'b1; op8 = 2'b10; a8 = 8'h80; b8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h3C; b8 = 8'h00;
      cyc = 1;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check("t5w8_done_cycle", cyc, 10);
      check("t5w8_hilo", {hi8, lo8}, 16'h0080);

      do_op(2'b01, 32'd6, 32'd7, 1'b1);
      check("t6_interfere", {hi, lo}, {32'd0, 32'd42});
      write_hl(1'b1, 1'b1, 32'hABCD);
      check("t6_write", {hi, lo}, {32'hABCD, 32'hABCD});

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         rx = $urandom;
         case ($urandom_range(0, 5))
            0: ry = '0;
            1: ry = 32'($urandom_range(1, 15));
            2: ry = 32'hFFFFFFFF;
            default: ry = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) write_hl(1'($urandom), 1'($urandom), $urandom);
         do_op(ro, rx, ry, 1'b0);
      end

      write_hl(1'b1, 1'b1, 32'h5A5A5A5A);
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_async", {busy, done, div_zero, hi, lo}, '0);
      exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check("rst_no_done", saw_done, 1'b0);
      check("rst_hilo", {hi, lo}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
